// File: rtl/umi_splitter_pkg.sv
// Shared UMI splitter definitions: opcode field layout and response classification.
package umi_splitter_pkg;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 8;
  localparam int RESP_BIT   = 0;
  localparam logic [OPCODE_W-1:0] OPCODE_INVALID = 8'h00;

  // Responses carry an odd opcode; OPCODE_INVALID is even, so it lands on the request side.
  function automatic logic is_response(input logic [OPCODE_W-1:0] opcode);
    return opcode[RESP_BIT];
  endfunction

endpackage

// File: rtl/umi_out_slice.sv
// One-entry registered UMI output buffer; accepts a new packet whenever empty or draining.
module umi_out_slice #(
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [CW-1:0] i_cmd,
  input  logic [AW-1:0] i_dstaddr,
  input  logic [AW-1:0] i_srcaddr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_out_ready,
  output logic [CW-1:0] o_cmd,
  output logic [AW-1:0] o_dstaddr,
  output logic [AW-1:0] o_srcaddr,
  output logic [DW-1:0] o_data
);

  logic          r_vld;
  logic [CW-1:0] r_cmd;
  logic [AW-1:0] r_dstaddr;
  logic [AW-1:0] r_srcaddr;
  logic [DW-1:0] r_data;
  logic          w_load;

  assign o_ready = !r_vld || i_out_ready;
  assign w_load  = i_valid && o_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld     <= 1'b0;
      r_cmd     <= '0;
      r_dstaddr <= '0;
      r_srcaddr <= '0;
      r_data    <= '0;
    end else if (w_load) begin
      r_vld     <= 1'b1;
      r_cmd     <= i_cmd;
      r_dstaddr <= i_dstaddr;
      r_srcaddr <= i_srcaddr;
      r_data    <= i_data;
    end else if (i_out_ready) begin
      // Fields hold their last value after a drain; only the valid flag clears.
      r_vld <= 1'b0;
    end
  end

  assign o_valid   = r_vld;
  assign o_cmd     = r_cmd;
  assign o_dstaddr = r_dstaddr;
  assign o_srcaddr = r_srcaddr;
  assign o_data    = r_data;

endmodule

// File: rtl/umi_req_resp_splitter.sv
// Routes each UMI packet to the response or request output by opcode bit 0.
// Optional handshake counters enabled with UMI_SPLITTER_STATS_EN.
module umi_req_resp_splitter
  import umi_splitter_pkg::*;
#(
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
`ifdef UMI_SPLITTER_STATS_EN
  output logic [31:0]   resp_count,
  output logic [31:0]   req_count,
`endif
  output logic          umi_resp_out_valid,
  output logic [CW-1:0] umi_resp_out_cmd,
  output logic [AW-1:0] umi_resp_out_dstaddr,
  output logic [AW-1:0] umi_resp_out_srcaddr,
  output logic [DW-1:0] umi_resp_out_data,
  input  logic          umi_resp_out_ready,
  output logic          umi_req_out_valid,
  output logic [CW-1:0] umi_req_out_cmd,
  output logic [AW-1:0] umi_req_out_dstaddr,
  output logic [AW-1:0] umi_req_out_srcaddr,
  output logic [DW-1:0] umi_req_out_data,
  input  logic          umi_req_out_ready
);

  logic w_is_resp;
  logic w_resp_ready;
  logic w_req_ready;

  assign w_is_resp    = is_response(umi_in_cmd[OPCODE_LSB +: OPCODE_W]);
  // Only the selected slice is consulted, so a stalled output never blocks the other.
  assign umi_in_ready = w_is_resp ? w_resp_ready : w_req_ready;

  umi_out_slice #(.DW(DW), .AW(AW), .CW(CW)) u_resp (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (umi_in_valid && w_is_resp),
    .o_ready     (w_resp_ready),
    .i_cmd       (umi_in_cmd),
    .i_dstaddr   (umi_in_dstaddr),
    .i_srcaddr   (umi_in_srcaddr),
    .i_data      (umi_in_data),
    .o_valid     (umi_resp_out_valid),
    .i_out_ready (umi_resp_out_ready),
    .o_cmd       (umi_resp_out_cmd),
    .o_dstaddr   (umi_resp_out_dstaddr),
    .o_srcaddr   (umi_resp_out_srcaddr),
    .o_data      (umi_resp_out_data)
  );

  umi_out_slice #(.DW(DW), .AW(AW), .CW(CW)) u_req (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (umi_in_valid && !w_is_resp),
    .o_ready     (w_req_ready),
    .i_cmd       (umi_in_cmd),
    .i_dstaddr   (umi_in_dstaddr),
    .i_srcaddr   (umi_in_srcaddr),
    .i_data      (umi_in_data),
    .o_valid     (umi_req_out_valid),
    .i_out_ready (umi_req_out_ready),
    .o_cmd       (umi_req_out_cmd),
    .o_dstaddr   (umi_req_out_dstaddr),
    .o_srcaddr   (umi_req_out_srcaddr),
    .o_data      (umi_req_out_data)
  );

`ifdef UMI_SPLITTER_STATS_EN
  logic [31:0] r_resp_count;
  logic [31:0] r_req_count;
  logic        w_hs;

  assign w_hs = umi_in_valid && umi_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_count <= '0;
      r_req_count  <= '0;
    end else begin
      if (w_hs && w_is_resp && (r_resp_count != 32'hFFFF_FFFF))
        r_resp_count <= r_resp_count + 32'd1;
      if (w_hs && !w_is_resp && (r_req_count != 32'hFFFF_FFFF))
        r_req_count <= r_req_count + 32'd1;
    end
  end

  assign resp_count = r_resp_count;
  assign req_count  = r_req_count;
`endif

endmodule

// File: tb/tb_umi_req_resp_splitter.sv
// Directed + random bench for umi_req_resp_splitter against a per-output queue model.
module tb_umi_req_resp_splitter;
  localparam int DW = 128;
  localparam int AW = 64;
  localparam int CW = 32;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } pkt_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_cmd = '0;
  logic [AW-1:0] in_dst = '0;
  logic [AW-1:0] in_src = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          rs_valid, rq_valid;
  logic          rs_ready = 1'b0, rq_ready = 1'b0;
  logic [CW-1:0] rs_cmd, rq_cmd;
  logic [AW-1:0] rs_dst, rs_src, rq_dst, rq_src;
  logic [DW-1:0] rs_data, rq_data;
`ifdef UMI_SPLITTER_STATS_EN
  logic [31:0]   resp_count, req_count;
`endif

  int   checks = 0;
  int   errors = 0;
  pkt_t rsp_q[$];
  pkt_t req_q[$];
  int   n_resp = 0;
  int   n_req  = 0;

  umi_req_resp_splitter #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .umi_in_valid         (in_valid),
    .umi_in_cmd           (in_cmd),
    .umi_in_dstaddr       (in_dst),
    .umi_in_srcaddr       (in_src),
    .umi_in_data          (in_data),
    .umi_in_ready         (in_ready),
`ifdef UMI_SPLITTER_STATS_EN
    .resp_count           (resp_count),
    .req_count            (req_count),
`endif
    .umi_resp_out_valid   (rs_valid),
    .umi_resp_out_cmd     (rs_cmd),
    .umi_resp_out_dstaddr (rs_dst),
    .umi_resp_out_srcaddr (rs_src),
    .umi_resp_out_data    (rs_data),
    .umi_resp_out_ready   (rs_ready),
    .umi_req_out_valid    (rq_valid),
    .umi_req_out_cmd      (rq_cmd),
    .umi_req_out_dstaddr  (rq_dst),
    .umi_req_out_srcaddr  (rq_src),
    .umi_req_out_data     (rq_data),
    .umi_req_out_ready    (rq_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t rnd_pkt(input logic [CW-1:0] cmd);
    pkt_t p;
    p.cmd = cmd;
    p.dst = {$urandom, $urandom};
    p.src = {$urandom, $urandom};
    for (int i = 0; i < DW / 32; i++) p.data[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic pkt_t mk_pkt(input logic [CW-1:0] cmd, input logic [AW-1:0] dst, input logic [DW-1:0] data);
    pkt_t p;
    p.cmd = cmd; p.dst = dst; p.src = '0; p.data = data;
    return p;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".rs_valid"}, DW'(rs_valid), DW'(rsp_q.size() != 0));
    chk({tag, ".rq_valid"}, DW'(rq_valid), DW'(req_q.size() != 0));
    if (rsp_q.size() != 0) begin
      chk({tag, ".rs_cmd"},  DW'(rs_cmd),  DW'(rsp_q[0].cmd));
      chk({tag, ".rs_dst"},  DW'(rs_dst),  DW'(rsp_q[0].dst));
      chk({tag, ".rs_src"},  DW'(rs_src),  DW'(rsp_q[0].src));
      chk({tag, ".rs_data"}, rs_data,      rsp_q[0].data);
    end
    if (req_q.size() != 0) begin
      chk({tag, ".rq_cmd"},  DW'(rq_cmd),  DW'(req_q[0].cmd));
      chk({tag, ".rq_dst"},  DW'(rq_dst),  DW'(req_q[0].dst));
      chk({tag, ".rq_src"},  DW'(rq_src),  DW'(req_q[0].src));
      chk({tag, ".rq_data"}, rq_data,      req_q[0].data);
    end
  endtask

  // One clock: drive at negedge, check state + ready, then advance the model at posedge.
  task automatic cycle(input string tag, input bit v, input pkt_t p, input bit rsr, input bit rqr);
    bit is_rsp, exp_rdy;
    @(negedge clk);
    in_valid = v; in_cmd = p.cmd; in_dst = p.dst; in_src = p.src; in_data = p.data;
    rs_ready = rsr; rq_ready = rqr;
    #1;
    check_outputs(tag);
    is_rsp  = p.cmd[0];
    exp_rdy = is_rsp ? (rsp_q.size() == 0 || rsr) : (req_q.size() == 0 || rqr);
    chk({tag, ".in_ready"}, DW'(in_ready), DW'(exp_rdy));
    @(posedge clk);
    if (rsr && rsp_q.size() != 0) void'(rsp_q.pop_front());
    if (rqr && req_q.size() != 0) void'(req_q.pop_front());
    if (v && exp_rdy) begin
      if (is_rsp) begin rsp_q.push_back(p); n_resp++; end
      else        begin req_q.push_back(p); n_req++;  end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".rs_valid"}, DW'(rs_valid), '0);
    chk({tag, ".rq_valid"}, DW'(rq_valid), '0);
    chk({tag, ".rs_fields"}, DW'({rs_cmd, rs_dst, rs_src}) | rs_data, '0);
    chk({tag, ".rq_fields"}, DW'({rq_cmd, rq_dst, rq_src}) | rq_data, '0);
    chk({tag, ".in_ready"}, DW'(in_ready), DW'(1));
`ifdef UMI_SPLITTER_STATS_EN
    chk({tag, ".resp_count"}, DW'(resp_count), '0);
    chk({tag, ".req_count"},  DW'(req_count),  '0);
`endif
  endtask

  initial begin
    pkt_t idle, a, b;
    idle = mk_pkt('0, '0, '0);

    // Reset state
    #1 check_reset_state("rst0");
    @(negedge clk); reset = 1'b0;

    // Basic routing
    cycle("basic_resp", 1, mk_pkt(32'h1, 64'h10, 128'hAB), 1, 1);
    cycle("basic_req",  1, mk_pkt(32'h2, 64'h10, 128'hAB), 1, 1);
    cycle("basic_inv",  1, mk_pkt(32'h0, 64'h20, 128'hCD), 1, 1);
    cycle("basic_idle", 0, idle, 1, 1);

    // Alternating stream, both readys high
    for (int i = 0; i < 8; i++)
      cycle("stream", 1, rnd_pkt({$urandom} & 32'hFFFF_FFFE | CW'(i % 2 == 0)), 1, 1);
    cycle("stream_end", 0, idle, 1, 1);

    // Independent backpressure: resp A stalls, req B passes, second resp blocked
    a = rnd_pkt(32'h0000_0003);
    b = rnd_pkt(32'h0000_0004);
    cycle("bp_A", 1, a, 0, 1);
    cycle("bp_B", 1, b, 0, 1);
    for (int i = 0; i < 3; i++)
      cycle("bp_stall", 1, rnd_pkt(32'h0000_0005), 0, 1);
    cycle("bp_release", 0, idle, 1, 1);
    cycle("bp_drained", 0, idle, 1, 1);

    // Drain and load in one cycle
    cycle("dl_fill", 1, rnd_pkt(32'h11), 1, 1);
    cycle("dl_C",    1, rnd_pkt(32'h13), 1, 1);
    cycle("dl_D",    1, rnd_pkt(32'h12), 1, 1);
    cycle("dl_chk",  0, idle, 1, 1);

    // Reset mid-stall with both buffers full
    cycle("mr_fill_rs", 1, rnd_pkt(32'h7), 0, 0);
    cycle("mr_fill_rq", 1, rnd_pkt(32'h8), 0, 0);
    cycle("mr_hold",    0, idle, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; in_cmd = '0;
    #2 reset = 1'b1;
    #1;
    check_reset_state("rst_mid");
    rsp_q.delete(); req_q.delete(); n_resp = 0; n_req = 0;
    @(negedge clk); reset = 1'b0;
    cycle("post_rst", 1, rnd_pkt(32'h9), 1, 1);
    cycle("post_rst2", 1, rnd_pkt(32'hA), 1, 1);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++)
      cycle("rand", ($urandom_range(0, 3) != 0), rnd_pkt($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
    cycle("rand_end", 0, idle, 1, 1);
    cycle("rand_end2", 0, idle, 1, 1);

`ifdef UMI_SPLITTER_STATS_EN
    #1;
    chk("stats_resp", DW'(resp_count), DW'(n_resp));
    chk("stats_req",  DW'(req_count),  DW'(n_req));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
